display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Owns the six-digit display of the lock and decides what it shows. It shares the display between two requesters: keypad entry echo and timed status messages (open, error, setup prompts). When neither is active it shows an idle pattern.
- Builds the bcdPac_t packet and drives the display controller's enable with clean single-cycle rising edges.
- Sits between the lock FSM / keypad buffer and the seven-segment controller.

Parameters:
HOLD_CYCLES, 100_000_000, cycles a message stays on display (2 s at 50 MHz); legal minimum 2.
IDLE_CODE, 5'h0F, digit code written to all six digits when idle (renders as a dash).
BLINK_CYCLES, 12_500_000, half-period of message blink; used only with DISP_ARB_BLINK_EN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
entry_valid  in  1  one-cycle strobe: entry_pkt holds new entry content
entry_pkt  in  bcdPac_t  entry digits BCD0..BCD5, 5 bits each
entry_clear  in  1  one-cycle strobe: drop entry content, revert to idle
msg_req  in  1  level; held by requester until msg_ack
msg_pkt  in  bcdPac_t  message digits; sampled only in the msg_ack cycle
msg_ack  out  1  one-cycle pulse: message accepted
msg_done  out  1  one-cycle pulse: message hold expired
busy  out  1  high while in SHOW_MSG
bcd_packet  out  bcdPac_t  registered packet to display controller
disp_enable  out  1  refresh strobe to display controller

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - bcd_packet all digits = IDLE_CODE.
  - disp_enable=0, msg_ack=0, msg_done=0, busy=0.
  - Entry shadow cleared (shadow_valid=0); hold counter=0.
  - dirty=1, so the idle pattern is pushed on the first cycle after reset.
- Refresh rule:
  - Any write to bcd_packet sets dirty.
  - When dirty=1 and disp_enable=0: disp_enable<=1 and dirty<=0.
  - When disp_enable=1: disp_enable<=0.
  - Consequences: every pulse lasts exactly 1 cycle, followed by at least 1 low cycle. Writes arriving closer together coalesce, and the latest packet wins. bcd_packet is stable throughout every disp_enable-high cycle.
  - Latency: input strobe edge E, bcd_packet written at E+1, disp_enable high in the cycle after E+1 (absent backlog).
- Entry shadow:
  - entry_valid always captures entry_pkt into the shadow and sets shadow_valid=1, in every state.
  - entry_clear sets shadow_valid=0.
  - Simultaneous entry_valid and entry_clear: clear wins.
- States:
  - IDLE: shows IDLE_CODE x6.
  - SHOW_ENTRY: shows the shadow.
  - SHOW_MSG: shows the message.
- Transitions:
  - IDLE/SHOW_ENTRY with msg_req=1: msg_ack pulse, load msg_pkt into bcd_packet, counter<=HOLD_CYCLES-1, go to SHOW_MSG. Message has priority over entry_valid in the same cycle; the entry is still captured in the shadow.
  - IDLE with entry_valid (no msg_req): write entry_pkt, go to SHOW_ENTRY.
  - SHOW_ENTRY with entry_valid: rewrite bcd_packet with the new entry.
  - SHOW_ENTRY with entry_clear: write IDLE_CODE x6, go to IDLE.
  - SHOW_MSG: msg_req is not acknowledged; entry strobes update only the shadow. Counter decrements each cycle.
  - SHOW_MSG at counter==0: msg_done pulse.
    - If msg_req=1: msg_ack in the same cycle, load the new msg_pkt, reload the counter, stay in SHOW_MSG (back-to-back, no flicker).
    - Else if shadow_valid: write the shadow, go to SHOW_ENTRY.
    - Else: write IDLE_CODE x6, go to IDLE.
- Timing:
  - msg_done occurs exactly HOLD_CYCLES cycles after msg_ack.
  - busy=1 from the cycle after msg_ack through the msg_done cycle inclusive.
- Reset mid-message: immediate return to reset values; no msg_done; a pending msg_req is acknowledged afresh after reset.

Optional Feature:
- DISP_ARB_BLINK_EN defined:
  - In SHOW_MSG a blink counter toggles the phase every BLINK_CYCLES cycles.
  - On phase change bcd_packet alternates between msg content and IDLE_CODE x6, each change triggering a refresh.
  - The phase starts at "message shown" on msg_ack and at every back-to-back reload.
  - Exit always writes the return content regardless of phase.
- Not defined: the message is shown steady; no blink counter is instantiated.

Test Plan:
- Reset release -> bcd_packet=5'h0F x6; disp_enable high exactly one cycle at cycle 1; msg_ack=msg_done=0.
- HOLD_CYCLES=8; entry_valid with {1,2,3,4,5,6} -> SHOW_ENTRY, one disp_enable pulse carrying that packet. Then entry_clear -> IDLE_CODE x6 plus one pulse.
- HOLD_CYCLES=8; entry shown, msg_req with {A,B,C,D,0,0} -> msg_ack 1 cycle, message pulse. Entry {7,7,7,7,7,7} strobed mid-message gives no pulse. msg_done 8 cycles after ack, then {7,...} displayed.
- entry_valid on two consecutive cycles -> single coalesced pulse or two pulses separated by at least 1 low cycle; last pulse carries the second packet.
- msg_req held high through expiry (HOLD_CYCLES=8) -> msg_done and msg_ack in the same cycle, new msg_pkt shown, busy stays 1; rst asserted 3 cycles into the message -> outputs return to reset values the next cycle, no msg_done.
- DISP_ARB_BLINK_EN defined, HOLD_CYCLES=8, BLINK_CYCLES=2 -> packet alternates msg/idle every 2 cycles with a pulse each change; entry content restored on exit.

Source files
------------

// File: rtl/display_arbiter.sv
//------------------------------------------------------------------------------
// display_arbiter : shares the six-digit lock display between keypad entry echo
//                   and timed status messages, with an idle pattern otherwise.
//                   Optional message blink is enabled by DISP_ARB_BLINK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package display_arbiter_pkg;
    // Digit i of the packet is BCDi (digit 0 in the least significant bits).
    typedef logic [5:0][4:0] bcdPac_t;
endpackage

module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 100_000_000,
    parameter logic [4:0]  IDLE_CODE    = 5'h0F,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    entry_valid,
    input  bcdPac_t entry_pkt,
    input  logic    entry_clear,
    input  logic    msg_req,
    input  bcdPac_t msg_pkt,
    output logic    msg_ack,
    output logic    msg_done,
    output logic    busy,
    output bcdPac_t bcd_packet,
    output logic    disp_enable
);

    localparam int               CNT_W     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam bcdPac_t          IDLE_PKT  = {6{IDLE_CODE}};

    if (HOLD_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_param_check
        $error("display_arbiter: HOLD_CYCLES must be >= 2 and BLINK_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHOW_ENTRY = 2'd1,
        SHOW_MSG   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    bcdPac_t          pkt_nxt;
    bcdPac_t          shadow;
    bcdPac_t          shadow_nxt;
    logic             shadow_valid;
    logic             shadow_valid_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic             expire;
    logic             load_msg;
    logic             write;
    logic             dirty;
    logic             launch;

`ifdef DISP_ARB_BLINK_EN
    localparam int               BLK_W      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLINK_LOAD = BLK_W'(BLINK_CYCLES - 1);

    logic [BLK_W-1:0] blink_cnt;
    logic             blink_shown;
    bcdPac_t          msg_hold;
    logic             blink_flip;
    bcdPac_t          blink_pkt;

    // Phase restarts at "message shown" on every accepted message.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_shown <= 1'b1;
            msg_hold    <= IDLE_PKT;
        end else if (load_msg) begin
            blink_cnt   <= BLINK_LOAD;
            blink_shown <= 1'b1;
            msg_hold    <= msg_pkt;
        end else if (state == SHOW_MSG) begin
            if (blink_cnt == '0) begin
                blink_cnt   <= BLINK_LOAD;
                blink_shown <= ~blink_shown;
            end else begin
                blink_cnt <= blink_cnt - 1'b1;
            end
        end
    end

    assign blink_flip = (state == SHOW_MSG) && (blink_cnt == '0);
    assign blink_pkt  = blink_shown ? IDLE_PKT : msg_hold;
`endif

    // A clear in the same cycle as a new entry wins.
    always_comb begin
        shadow_nxt       = entry_valid ? entry_pkt : shadow;
        shadow_valid_nxt = entry_clear ? 1'b0 : (entry_valid ? 1'b1 : shadow_valid);
    end

    assign expire = (state == SHOW_MSG) && (hold_cnt == '0);

    always_comb begin
        state_nxt = state;
        pkt_nxt   = bcd_packet;
        write     = 1'b0;
        load_msg  = 1'b0;
        case (state)
            IDLE: begin
                if (msg_req) begin
                    load_msg = 1'b1;
                end else if (entry_valid && !entry_clear) begin
                    state_nxt = SHOW_ENTRY;
                    pkt_nxt   = entry_pkt;
                    write     = 1'b1;
                end
            end
            SHOW_ENTRY: begin
                if (msg_req) begin
                    load_msg = 1'b1;
                end else if (entry_clear) begin
                    state_nxt = IDLE;
                    pkt_nxt   = IDLE_PKT;
                    write     = 1'b1;
                end else if (entry_valid) begin
                    pkt_nxt = entry_pkt;
                    write   = 1'b1;
                end
            end
            SHOW_MSG: begin
                if (expire) begin
                    if (msg_req) begin
                        load_msg = 1'b1;
                    end else if (shadow_valid_nxt) begin
                        state_nxt = SHOW_ENTRY;
                        pkt_nxt   = shadow_nxt;
                        write     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        pkt_nxt   = IDLE_PKT;
                        write     = 1'b1;
                    end
                end
`ifdef DISP_ARB_BLINK_EN
                else if (blink_flip) begin
                    pkt_nxt = blink_pkt;
                    write   = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        if (load_msg) begin
            state_nxt = SHOW_MSG;
            pkt_nxt   = msg_pkt;
            write     = 1'b1;
        end
    end

    // A write landing on the launch edge is carried by that same pulse.
    assign launch = dirty & ~disp_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bcd_packet   <= IDLE_PKT;
            disp_enable  <= 1'b0;
            dirty        <= 1'b1;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            bcd_packet   <= pkt_nxt;
            disp_enable  <= launch;
            dirty        <= (dirty | write) & ~launch;
            shadow       <= shadow_nxt;
            shadow_valid <= shadow_valid_nxt;
            if (load_msg) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == SHOW_MSG && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign msg_ack  = load_msg & ~rst;
    assign msg_done = expire & ~rst;
    assign busy     = (state == SHOW_MSG);

endmodule

`default_nettype wire

// File: tb/tb_display_arbiter.sv
//------------------------------------------------------------------------------
// tb_display_arbiter : directed stimulus for display_arbiter, checked every
//                      cycle against a message-age / pending-refresh model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_display_arbiter;
    import display_arbiter_pkg::*;

    localparam int         HOLD      = 8;
    localparam int         BLINK     = 2;
    localparam logic [4:0] IDLE_CODE = 5'h0F;
    localparam bcdPac_t    IDLE6     = {6{IDLE_CODE}};
    localparam int         M_IDLE    = 0;
    localparam int         M_ENTRY   = 1;
    localparam int         M_MSG     = 2;
`ifdef DISP_ARB_BLINK_EN
    localparam int         MSG_WINDOW_PULSES = 5;
`else
    localparam int         MSG_WINDOW_PULSES = 2;
`endif

    logic    clk = 1'b0;
    logic    rst;
    logic    entry_valid;
    logic    entry_clear;
    logic    msg_req;
    bcdPac_t entry_pkt;
    bcdPac_t msg_pkt;
    logic    msg_ack;
    logic    msg_done;
    logic    busy;
    bcdPac_t bcd_packet;
    logic    disp_enable;

    int n_cmp = 0;
    int n_bad = 0;

    display_arbiter #(
        .HOLD_CYCLES  (HOLD),
        .IDLE_CODE    (IDLE_CODE),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_valid (entry_valid),
        .entry_pkt   (entry_pkt),
        .entry_clear (entry_clear),
        .msg_req     (msg_req),
        .msg_pkt     (msg_pkt),
        .msg_ack     (msg_ack),
        .msg_done    (msg_done),
        .busy        (busy),
        .bcd_packet  (bcd_packet),
        .disp_enable (disp_enable)
    );

    always #5 clk = ~clk;

    function automatic bcdPac_t mk(input logic [4:0] d0, d1, d2, d3, d4, d5);
        bcdPac_t r;
        r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3; r[4] = d4; r[5] = d5;
        return r;
    endfunction

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkp(input string name, input bcdPac_t act, input bcdPac_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state describes the cycle currently being observed.
    int      t = 0;
    bit      mvalid = 1'b0;
    int      mode;
    int      age;
    bcdPac_t shown;
    bcdPac_t mmsg;
    bcdPac_t msh;
    bit      msv;
    bit      de_prev;
    bit      pend;
    int      pend_vis;
    int      pulses = 0;
    int      ack_cyc = 0;
    int      done_cyc = 0;

    always @(negedge clk) begin : p_cmp
        bit      e_ack, e_done, e_busy, e_de, nsv, wr;
        bcdPac_t nsh, nshown;
        t++;
        if (disp_enable === 1'b1) pulses++;
        if (msg_ack === 1'b1) ack_cyc = t;
        if (msg_done === 1'b1) done_cyc = t;

        if (mvalid) begin
            e_busy = (mode == M_MSG);
            e_done = !rst && mode == M_MSG && age == HOLD;
            e_ack  = !rst && msg_req && (mode != M_MSG || age == HOLD);
            e_de   = !de_prev && pend && pend_vis <= t - 1;
            chkb("msg_ack", msg_ack, e_ack);
            chkb("msg_done", msg_done, e_done);
            chkb("busy", busy, e_busy);
            chkb("disp_enable", disp_enable, e_de);
            chkp("bcd_packet", bcd_packet, shown);
            if (e_de) pend = 1'b0;
            de_prev = e_de;
        end

        if (rst) begin
            mvalid   = 1'b1;
            mode     = M_IDLE;
            age      = 0;
            shown    = IDLE6;
            mmsg     = IDLE6;
            msh      = '0;
            msv      = 1'b0;
            de_prev  = 1'b0;
            pend     = 1'b1;
            pend_vis = t + 1;
        end else if (mvalid) begin
            nsh    = entry_valid ? entry_pkt : msh;
            nsv    = entry_clear ? 1'b0 : (entry_valid ? 1'b1 : msv);
            wr     = 1'b0;
            nshown = shown;
            if (mode != M_MSG && msg_req) begin
                mode = M_MSG; age = 1; mmsg = msg_pkt; nshown = msg_pkt; wr = 1'b1;
            end else if (mode == M_IDLE) begin
                if (entry_valid && !entry_clear) begin
                    mode = M_ENTRY; nshown = entry_pkt; wr = 1'b1;
                end
            end else if (mode == M_ENTRY) begin
                if (entry_clear) begin
                    mode = M_IDLE; nshown = IDLE6; wr = 1'b1;
                end else if (entry_valid) begin
                    nshown = entry_pkt; wr = 1'b1;
                end
            end else if (age == HOLD) begin
                if (msg_req) begin
                    age = 1; mmsg = msg_pkt; nshown = msg_pkt; wr = 1'b1;
                end else if (nsv) begin
                    mode = M_ENTRY; nshown = nsh; wr = 1'b1;
                end else begin
                    mode = M_IDLE; nshown = IDLE6; wr = 1'b1;
                end
            end else begin
                age++;
`ifdef DISP_ARB_BLINK_EN
                if ((age - 1) % BLINK == 0) begin
                    nshown = (((age - 1) / BLINK) % 2 == 0) ? mmsg : IDLE6;
                    wr = 1'b1;
                end
`endif
            end
            msh   = nsh;
            msv   = nsv;
            shown = nshown;
            if (wr && !pend) begin
                pend     = 1'b1;
                pend_vis = t + 1;
            end
        end
    end

    task automatic drive(input logic r, input logic ev, input logic ec, input logic mr,
                         input bcdPac_t ep, input bcdPac_t mp);
        rst = r; entry_valid = ev; entry_clear = ec; msg_req = mr;
        entry_pkt = ep; msg_pkt = mp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin : p_stim
        bcdPac_t e1, e2, e3, e7, m1, m2, m3;
        int      p0;
        e1 = mk(5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 5'h6);
        e2 = mk(5'h2, 5'h2, 5'h2, 5'h2, 5'h2, 5'h2);
        e3 = mk(5'h3, 5'h3, 5'h3, 5'h3, 5'h3, 5'h3);
        e7 = mk(5'h7, 5'h7, 5'h7, 5'h7, 5'h7, 5'h7);
        m1 = mk(5'hA, 5'hB, 5'hC, 5'hD, 5'h0, 5'h0);
        m2 = mk(5'h9, 5'h8, 5'h7, 5'h6, 5'h5, 5'h4);
        m3 = mk(5'h1, 5'h1, 5'h0, 5'h0, 5'h1, 5'h1);

        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        p0 = pulses;
        idle(4);
        chkp("reset_idle_pkt", bcd_packet, mk(5'hF, 5'hF, 5'hF, 5'hF, 5'hF, 5'hF));
        chki("reset_pulse_count", pulses - p0, 1);

        p0 = pulses;
        drive(1'b0, 1'b1, 1'b0, 1'b0, e1, '0);
        idle(3);
        chkp("entry_pkt", bcd_packet, e1);
        chki("entry_pulse_count", pulses - p0, 1);

        p0 = pulses;
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        idle(3);
        chkp("clear_pkt", bcd_packet, IDLE6);
        chki("clear_pulse_count", pulses - p0, 1);

        drive(1'b0, 1'b1, 1'b0, 1'b0, e1, '0);
        idle(3);
        p0 = pulses;
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0, m1);
        chkp("msg_pkt_shown", bcd_packet, m1);
        chkb("msg_busy", busy, 1'b1);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, e7, '0);
        idle(8);
        chkp("entry_after_msg", bcd_packet, e7);
        chki("msg_window_pulses", pulses - p0, MSG_WINDOW_PULSES);
        chki("ack_to_done", done_cyc - ack_cyc, HOLD);

        drive(1'b0, 1'b1, 1'b0, 1'b0, e2, '0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, e3, '0);
        idle(4);
        chkp("coalesced_entry", bcd_packet, e3);

        drive(1'b0, 1'b0, 1'b0, 1'b1, '0, m1);
        for (int i = 0; i < HOLD; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, '0, m2);
        chkp("back_to_back_pkt", bcd_packet, m2);
        chkb("back_to_back_busy", busy, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        chkb("reset_mid_busy", busy, 1'b0);
        chkp("reset_mid_pkt", bcd_packet, IDLE6);
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0, m1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0, m3);
        idle(12);
        chkp("msg_exit_idle", bcd_packet, IDLE6);
        chki("fresh_ack_to_done", done_cyc - ack_cyc, HOLD);

        drive(1'b0, 1'b1, 1'b0, 1'b0, e1, '0);
        idle(3);
        drive(1'b0, 1'b1, 1'b1, 1'b0, e2, '0);
        idle(3);
        chkp("clear_wins_pkt", bcd_packet, IDLE6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
